ex_mem_buf: RTL and testbench
=============================

EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32, data-path width of all word-wide payload fields.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1 bit: discard all buffered entries (trap, interrupt, branch redirect).
REQ-005 SHALL have port ex_valid, input, 1 bit: EX stage presents an entry.
REQ-006 SHALL have port ex_ready, output, 1 bit: buffer accepts an entry this cycle.
REQ-007 SHALL have ports ex_WB/mem_WB, in/out, 2 bits: write-back control.
REQ-008 SHALL have ports ex_M/mem_M, in/out, 2 bits: memory read/write control.
REQ-009 SHALL have ports ex_rd/mem_rd, in/out, 5 bits: destination register index.
REQ-010 SHALL have ports ex_alu_out/mem_alu_out, in/out, XLEN bits: ALU result or memory address.
REQ-011 SHALL have ports ex_store_data/mem_store_data, in/out, XLEN bits: store data.
REQ-012 SHALL have ports ex_PCadd4/mem_PCadd4 and ex_instruction/mem_instruction, in/out, XLEN bits each: PC+4 and instruction word.
REQ-013 SHALL have ports ex_csr_wr_en/mem_csr_wr_en (1 bit), ex_csr_addr/mem_csr_addr (12 bits) and ex_csr_wdata/mem_csr_wdata (XLEN bits), in/out: CSR write request.
REQ-014 SHALL have port mem_valid, output, 1 bit: head entry valid toward the MEM stage.
REQ-015 SHALL have port mem_ready, input, 1 bit: MEM stage consumes the head entry.

Function
REQ-016 SHALL be a 2-entry FIFO with states EMPTY, ONE and FULL; the count is 0, 1 or 2.
REQ-017 SHALL define push = ex_valid & ex_ready and pop = mem_valid & mem_ready.
REQ-018 SHALL drive ex_ready from a flop: high in EMPTY and ONE, low in FULL; it SHALL have no combinational path from mem_ready.
REQ-019 SHALL drive mem_valid high exactly when the state is ONE or FULL; all mem_* outputs SHALL come from head-entry flops.
REQ-020 SHALL make a pushed entry visible on mem_* in the cycle after the push (latency 1) when the buffer was EMPTY.
REQ-021 SHALL transition EMPTY→ONE on push; ONE→FULL on push without pop; ONE→EMPTY on pop without push; ONE→ONE on simultaneous push and pop, with the new entry becoming head; FULL→ONE on pop, with the second entry becoming head.
REQ-022 SHALL ignore ex_valid in FULL; an entry that is not pushed is not captured and not lost, because EX holds it while ex_ready is low.
REQ-023 SHALL hold mem_* outputs stable while mem_valid & !mem_ready.
REQ-024 SHALL, on flush, go to EMPTY at the next edge, override push and pop in that cycle, and force mem_WB, mem_M and mem_csr_wr_en of both entries to 0.
REQ-025 SHALL preserve entry order with no duplication or loss across any push/pop sequence.

Reset
REQ-026 SHALL, while rst=0, clear the state to EMPTY, set ex_ready=1 and mem_valid=0, and drive all payload outputs to 0 immediately.
REQ-027 SHALL, when reset is asserted mid-operation, discard all entries; the first push after release behaves as from EMPTY.

Configuration
REQ-028 SHALL, with EX_MEM_CSR_EN defined, buffer and forward the ex_csr_* fields with the entry.
REQ-029 SHALL, without EX_MEM_CSR_EN, keep the CSR ports, tie mem_csr_* outputs to 0, instantiate no CSR storage, and leave all other behaviour identical.

Verification
REQ-030 SHALL cover: after reset release, push ALU 0x0000_1234, rd=5, with mem_ready=1 -> mem_valid=1 next cycle with mem_alu_out=0x1234 and mem_rd=5; mem_valid=0 the cycle after.
REQ-031 SHALL cover: mem_ready=0, push A=0x11 then B=0x22 -> ex_ready=0 after the second push, mem_alu_out holds 0x11; raise mem_ready -> 0x11 then 0x22 on consecutive cycles.
REQ-032 SHALL cover: state ONE, simultaneous push 0x33 and pop -> state stays ONE, mem_alu_out=0x33 next cycle.
REQ-033 SHALL cover: FULL with ex_M=2'b01 entries, flush=1 together with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, mem_M=0.
REQ-034 SHALL cover: FULL, rst pulsed low mid-cycle -> mem_valid=0 and outputs 0 with no clock edge.
REQ-035 SHALL cover: push with ex_csr_wr_en=1, ex_csr_addr=0x300 -> mem_csr_addr=0x300 with the macro defined, 0 without it.

Source files
------------

// File: rtl/ex_mem_buf.sv
// EX/MEM pipeline buffer: a 2-entry FIFO with registered ready/valid on both sides.
// Optional macro EX_MEM_CSR_EN carries the CSR write request with each entry.
module ex_mem_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_WB,
  input  logic [1:0]      ex_M,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_PCadd4,
  input  logic [XLEN-1:0] ex_instruction,
  input  logic            ex_csr_wr_en,
  input  logic [11:0]     ex_csr_addr,
  input  logic [XLEN-1:0] ex_csr_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [1:0]      mem_WB,
  output logic [1:0]      mem_M,
  output logic [4:0]      mem_rd,
  output logic [XLEN-1:0] mem_alu_out,
  output logic [XLEN-1:0] mem_store_data,
  output logic [XLEN-1:0] mem_PCadd4,
  output logic [XLEN-1:0] mem_instruction,
  output logic            mem_csr_wr_en,
  output logic [11:0]     mem_csr_addr,
  output logic [XLEN-1:0] mem_csr_wdata,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]      wb;
    logic [1:0]      m;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid are flops, so neither side sees a comb path back.
  state_t state, state_nxt;
  entry_t head, sec, in_e;
  logic   push, pop, load_head, load_sec, shift;

  assign push      = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;
  assign dbg_state = state;
  assign in_e      = '{wb: ex_WB, m: ex_M, rd: ex_rd, alu: ex_alu_out,
                       store: ex_store_data, pc4: ex_PCadd4, instr: ex_instruction};

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_sec  = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
        ONE: case ({push, pop})
          2'b10:   begin state_nxt = FULL;  load_sec = 1'b1;  end
          2'b01:   begin state_nxt = EMPTY;                   end
          2'b11:   begin state_nxt = ONE;   load_head = 1'b1; end
          default: state_nxt = ONE;
        endcase
        FULL: if (pop) begin
          state_nxt = ONE;
          shift     = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      ex_ready  <= 1'b1;
      mem_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ex_ready  <= (state_nxt != FULL);
      mem_valid <= (state_nxt != EMPTY);
    end
  end

  // Flush only kills the side-effecting controls; stale data is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      sec  <= '0;
    end else if (flush) begin
      head.wb <= 2'b00;
      head.m  <= 2'b00;
      sec.wb  <= 2'b00;
      sec.m   <= 2'b00;
    end else begin
      if (load_head)  head <= in_e;
      else if (shift) head <= sec;
      if (load_sec)   sec  <= in_e;
    end
  end

  assign mem_WB          = head.wb;
  assign mem_M           = head.m;
  assign mem_rd          = head.rd;
  assign mem_alu_out     = head.alu;
  assign mem_store_data  = head.store;
  assign mem_PCadd4      = head.pc4;
  assign mem_instruction = head.instr;

`ifdef EX_MEM_CSR_EN
  logic            csr_en_h, csr_en_s;
  logic [11:0]     csr_addr_h, csr_addr_s;
  logic [XLEN-1:0] csr_wdata_h, csr_wdata_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_en_h    <= 1'b0;
      csr_en_s    <= 1'b0;
      csr_addr_h  <= '0;
      csr_addr_s  <= '0;
      csr_wdata_h <= '0;
      csr_wdata_s <= '0;
    end else if (flush) begin
      csr_en_h <= 1'b0;
      csr_en_s <= 1'b0;
    end else begin
      if (load_head) begin
        csr_en_h    <= ex_csr_wr_en;
        csr_addr_h  <= ex_csr_addr;
        csr_wdata_h <= ex_csr_wdata;
      end else if (shift) begin
        csr_en_h    <= csr_en_s;
        csr_addr_h  <= csr_addr_s;
        csr_wdata_h <= csr_wdata_s;
      end
      if (load_sec) begin
        csr_en_s    <= ex_csr_wr_en;
        csr_addr_s  <= ex_csr_addr;
        csr_wdata_s <= ex_csr_wdata;
      end
    end
  end

  assign mem_csr_wr_en = csr_en_h;
  assign mem_csr_addr  = csr_addr_h;
  assign mem_csr_wdata = csr_wdata_h;
`else
  logic unused_csr;
  assign unused_csr    = ^{ex_csr_wr_en, ex_csr_addr, ex_csr_wdata};
  assign mem_csr_wr_en = 1'b0;
  assign mem_csr_addr  = '0;
  assign mem_csr_wdata = '0;
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
// Bench for ex_mem_buf: directed scenarios then random traffic, checked against
// a queue-based FIFO model.
module tb_ex_mem_buf;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] store;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } ent_t;
  localparam int EW = $bits(ent_t);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, ex_valid, mem_ready;

  ent_t in_e;
  logic            ex_ready, mem_valid;
  logic [1:0]      mem_WB, mem_M, dbg_state;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_alu_out, mem_store_data, mem_PCadd4, mem_instruction, mem_csr_wdata;
  logic            mem_csr_wr_en;
  logic [11:0]     mem_csr_addr;

  ex_mem_buf #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_WB(in_e.wb), .ex_M(in_e.m), .ex_rd(in_e.rd), .ex_alu_out(in_e.alu),
    .ex_store_data(in_e.store), .ex_PCadd4(in_e.pc4), .ex_instruction(in_e.instr),
    .ex_csr_wr_en(in_e.csr_en), .ex_csr_addr(in_e.csr_addr), .ex_csr_wdata(in_e.csr_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_WB(mem_WB), .mem_M(mem_M), .mem_rd(mem_rd), .mem_alu_out(mem_alu_out),
    .mem_store_data(mem_store_data), .mem_PCadd4(mem_PCadd4), .mem_instruction(mem_instruction),
    .mem_csr_wr_en(mem_csr_wr_en), .mem_csr_addr(mem_csr_addr), .mem_csr_wdata(mem_csr_wdata),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.wb        = 2'($urandom_range(0, 3));
    e.m         = 2'($urandom_range(0, 3));
    e.rd        = 5'($urandom_range(0, 31));
    e.alu       = $urandom;
    e.store     = $urandom;
    e.pc4       = $urandom;
    e.instr     = $urandom;
    e.csr_en    = 1'($urandom_range(0, 1));
    e.csr_addr  = 12'($urandom_range(0, 4095));
    e.csr_wdata = $urandom;
    return e;
  endfunction

  function automatic logic [191:0] obs_pay();
    return {55'd0, mem_WB, mem_M, mem_rd, mem_alu_out, mem_store_data, mem_PCadd4, mem_instruction};
  endfunction

  function automatic logic [191:0] obs_csr();
    return {147'd0, mem_csr_wr_en, mem_csr_addr, mem_csr_wdata};
  endfunction

  task automatic check_outputs();
    ent_t h;
    check("ex_ready", ex_ready, exp_q.size() < 2);
    check("mem_valid", mem_valid, exp_q.size() > 0);
    check("count", dbg_state, exp_q.size());
    if (exp_q.size() > 0) begin
      h = ent_t'(exp_q[0]);
      check("payload", obs_pay(),
            {55'd0, h.wb, h.m, h.rd, h.alu, h.store, h.pc4, h.instr});
`ifdef EX_MEM_CSR_EN
      check("csr", obs_csr(), {147'd0, h.csr_en, h.csr_addr, h.csr_wdata});
`endif
    end
`ifndef EX_MEM_CSR_EN
    check("csr_tied", obs_csr(), 192'd0);
`endif
  endtask

  // One clock: apply FIFO rules to the model using pre-edge inputs, then compare.
  task automatic tick();
    bit do_push, do_pop;
    do_push = ex_valid && (exp_q.size() < 2);
    do_pop  = mem_ready && (exp_q.size() > 0);
    if (flush) exp_q.delete();
    else begin
      if (do_pop)  exp_q.delete(0);
      if (do_push) exp_q.push_back(EW'(in_e));
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input ent_t e);
    ex_valid = v;
    in_e     = e;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, mem_valid, 1'b0);
    check({tag, "_ready"}, ex_ready, 1'b1);
    check({tag, "_pay"}, obs_pay(), 192'd0);
    check({tag, "_csr"}, obs_csr(), 192'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ent_t e;
    rst = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    drive(1'b0, '0);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // single push, latency 1, then drains
    mem_ready = 1'b1;
    e = rand_ent(); e.alu = 32'h0000_1234; e.rd = 5'd5;
    drive(1'b1, e);
    tick();
    check("r30_alu", mem_alu_out, 32'h1234);
    check("r30_rd", mem_rd, 5'd5);
    drive(1'b0, rand_ent());
    tick();
    check("r30_drain", mem_valid, 1'b0);

    // fill with back-pressure, ignored third offer, then drain in order
    mem_ready = 1'b0;
    e = rand_ent(); e.alu = 32'h11; drive(1'b1, e); tick();
    e = rand_ent(); e.alu = 32'h22; drive(1'b1, e); tick();
    check("r31_ready", ex_ready, 1'b0);
    check("r31_hold", mem_alu_out, 32'h11);
    e = rand_ent(); e.alu = 32'h99; drive(1'b1, e); tick();
    check("r31_ignore", mem_alu_out, 32'h11);
    drive(1'b0, rand_ent()); mem_ready = 1'b1;
    tick();
    check("r31_second", mem_alu_out, 32'h22);
    tick();
    check("r31_empty", mem_valid, 1'b0);

    // simultaneous push and pop in ONE
    mem_ready = 1'b0;
    e = rand_ent(); e.alu = 32'h44; drive(1'b1, e); tick();
    mem_ready = 1'b1;
    e = rand_ent(); e.alu = 32'h33; drive(1'b1, e); tick();
    check("r32_count", dbg_state, 2'd1);
    check("r32_alu", mem_alu_out, 32'h33);
    drive(1'b0, rand_ent()); tick();

    // flush while FULL overrides a concurrent push
    mem_ready = 1'b0;
    e = rand_ent(); e.m = 2'b01; e.wb = 2'b11; e.csr_en = 1'b1; drive(1'b1, e); tick();
    e = rand_ent(); e.m = 2'b01; e.wb = 2'b11; e.csr_en = 1'b1; drive(1'b1, e); tick();
    flush = 1'b1;
    e = rand_ent(); e.m = 2'b01; drive(1'b1, e);
    tick();
    flush = 1'b0;
    check("r33_valid", mem_valid, 1'b0);
    check("r33_ready", ex_ready, 1'b1);
    check("r33_m", mem_M, 2'b00);
    check("r33_wb", mem_WB, 2'b00);
    check("r33_csr_en", mem_csr_wr_en, 1'b0);
    drive(1'b0, rand_ent()); tick();

    // asynchronous reset mid-cycle while FULL
    drive(1'b1, rand_ent()); tick();
    drive(1'b1, rand_ent()); tick();
    #2 rst = 1'b0;
    #1 check_all_zero("r34");
    exp_q.delete();
    #2 rst = 1'b1;
    mem_ready = 1'b1;
    drive(1'b1, rand_ent()); tick();

    // CSR forwarding
    e = rand_ent(); e.csr_en = 1'b1; e.csr_addr = 12'h300; drive(1'b1, e); tick();
`ifdef EX_MEM_CSR_EN
    check("r35_addr", mem_csr_addr, 12'h300);
`else
    check("r35_addr", mem_csr_addr, 12'h000);
`endif
    drive(1'b0, rand_ent()); tick();

    // random traffic; EX holds an offer until it is taken
    for (int i = 0; i < 400; i++) begin
      if (!(ex_valid && !ex_ready)) drive(1'($urandom_range(0, 3) != 0), rand_ent());
      mem_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
